// File: rtl/id_ex_skid_if.sv
// ID/EX handshake bundle: ID-side fields in, EX-side registered fields out.
// master = environment (ID producer / EX consumer), slave = the stage.
interface id_ex_skid_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int M_W    = 3,
  parameter int EX_W   = 4
) ();
  logic              in_valid;
  logic              in_ready;
  logic [WB_W-1:0]   ctlwb_out;
  logic [M_W-1:0]    ctlm_out;
  logic [EX_W-1:0]   ctlex_out;
  logic [DATA_W-1:0] npc;
  logic [DATA_W-1:0] readdat1;
  logic [DATA_W-1:0] readdat2;
  logic [DATA_W-1:0] signext_out;
  logic [REG_W-1:0]  instr_2016;
  logic [REG_W-1:0]  instr_1511;

  logic              out_valid;
  logic              out_ready;
  logic [WB_W-1:0]   wb_ctlout;
  logic [M_W-1:0]    m_ctlout;
  logic [EX_W-1:0]   ex_ctlout;
  logic [DATA_W-1:0] npcout;
  logic [DATA_W-1:0] rdata1out;
  logic [DATA_W-1:0] rdata2out;
  logic [DATA_W-1:0] s_extendout;
  logic [REG_W-1:0]  instrout_2016;
  logic [REG_W-1:0]  instrout_1511;

  modport slave (
    input  in_valid, ctlwb_out, ctlm_out,
    input  ctlex_out, npc, readdat1,
    input  readdat2, signext_out,
    input  instr_2016, instr_1511,
    input  out_ready,
    output in_ready, out_valid,
    output wb_ctlout, m_ctlout, ex_ctlout,
    output npcout, rdata1out, rdata2out,
    output s_extendout,
    output instrout_2016, instrout_1511
  );

  modport master (
    output in_valid, ctlwb_out, ctlm_out,
    output ctlex_out, npc, readdat1,
    output readdat2, signext_out,
    output instr_2016, instr_1511,
    output out_ready,
    input  in_ready, out_valid,
    input  wb_ctlout, m_ctlout, ex_ctlout,
    input  npcout, rdata1out, rdata2out,
    input  s_extendout,
    input  instrout_2016, instrout_1511
  );
endinterface

// File: rtl/id_ex_skid.sv
// ID/EX pipeline register with 2-entry skid buffer (main + skid, FIFO).
// Optional stall counter under macro ID_EX_STALL_CNT_EN.
module id_ex_skid #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2,
  parameter int M_W    = 3,
  parameter int EX_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  id_ex_skid_if.slave bus
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [M_W-1:0]    m;
    logic [EX_W-1:0]   ex;
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] sext;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
  } ent_t;

  ent_t main_q, main_d;
  ent_t skid_q, skid_d;
  ent_t in_e;
  logic main_v_q, main_v_d;
  logic skid_v_q, skid_v_d;
  logic in_ready_q, in_ready_d;
  logic push, pop;

  always_comb begin
    in_e      = '0;
    in_e.wb   = bus.ctlwb_out;
    in_e.m    = bus.ctlm_out;
    in_e.ex   = bus.ctlex_out;
    in_e.npc  = bus.npc;
    in_e.rd1  = bus.readdat1;
    in_e.rd2  = bus.readdat2;
    in_e.sext = bus.signext_out;
    in_e.rt   = bus.instr_2016;
    in_e.rd   = bus.instr_1511;
  end

  assign push = bus.in_valid & in_ready_q;
  assign pop  = main_v_q & bus.out_ready;

  always_comb begin
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      unique case (1'b1)
        !main_v_q: begin
          if (push) begin
            main_d   = in_e;
            main_v_d = 1'b1;
          end
        end
        main_v_q & !pop: begin
          if (push) begin
            skid_d   = in_e;
            skid_v_d = 1'b1;
          end
        end
        pop & skid_v_q: begin
          main_d   = skid_q;
          skid_v_d = 1'b0;
        end
        pop & !skid_v_q: begin
          if (push) main_d = in_e;
          main_v_d = push;
        end
        default: ;
      endcase
    end
    // Bubble: control reads zero while data keeps its last value
    if (!main_v_d) begin
      main_d.wb = '0;
      main_d.m  = '0;
      main_d.ex = '0;
    end
    in_ready_d = !skid_v_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = main_v_q;
  assign bus.wb_ctlout     = main_q.wb;
  assign bus.m_ctlout      = main_q.m;
  assign bus.ex_ctlout     = main_q.ex;
  assign bus.npcout        = main_q.npc;
  assign bus.rdata1out     = main_q.rd1;
  assign bus.rdata2out     = main_q.rd2;
  assign bus.s_extendout   = main_q.sext;
  assign bus.instrout_2016 = main_q.rt;
  assign bus.instrout_1511 = main_q.rd;

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall;

  // A flushed entry is discarded, so that cycle is not a stall
  assign stall = main_v_q & !bus.out_ready & !flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
// Directed self-checking bench for id_ex_skid.
// Covers reset, latency, skid fill/drain, streaming, flush, async reset.
module tb_id_ex_skid;
  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  id_ex_skid_if #(
    .DATA_W(32), .REG_W(5), .WB_W(2),
    .M_W(3), .EX_W(4)
  ) bus ();

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  id_ex_skid #(
    .DATA_W(32), .REG_W(5), .WB_W(2),
    .M_W(3), .EX_W(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef ID_EX_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [31:0] n,
                       input logic [31:0] r1,
                       input logic [31:0] r2,
                       input logic [31:0] se,
                       input logic [4:0] rt,
                       input logic [4:0] rd,
                       input logic [1:0] wb,
                       input logic [2:0] m,
                       input logic [3:0] ex);
    bus.in_valid    = v;
    bus.npc         = n;
    bus.readdat1    = r1;
    bus.readdat2    = r2;
    bus.signext_out = se;
    bus.instr_2016  = rt;
    bus.instr_1511  = rd;
    bus.ctlwb_out   = wb;
    bus.ctlm_out    = m;
    bus.ctlex_out   = ex;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    flush  = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    #12;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_wb", bus.wb_ctlout, 0);
    chk("rst_ex", bus.ex_ctlout, 0);
    chk("rst_npc", bus.npcout, 0);
    chk("rst_rd1", bus.rdata1out, 0);
    rst = 1'b1;

    // single entry, one-cycle latency
    step();
    drive(1, 10, 15, 20, 20, 2, 2, 1, 1, 2);
    bus.out_ready = 1'b1;
    step();
    idle();
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_npc", bus.npcout, 10);
    chk("t1_rd1", bus.rdata1out, 15);
    chk("t1_rd2", bus.rdata2out, 20);
    chk("t1_sext", bus.s_extendout, 20);
    chk("t1_rt", bus.instrout_2016, 2);
    chk("t1_rd", bus.instrout_1511, 2);
    chk("t1_wb", bus.wb_ctlout, 1);
    chk("t1_m", bus.m_ctlout, 1);
    chk("t1_ex", bus.ex_ctlout, 2);
    chk("t1_ready", bus.in_ready, 1);
    step();
    chk("t1_bub_valid", bus.out_valid, 0);
    chk("t1_bub_wb", bus.wb_ctlout, 0);
    chk("t1_bub_m", bus.m_ctlout, 0);
    chk("t1_bub_ex", bus.ex_ctlout, 0);
    chk("t1_hold_npc", bus.npcout, 10);

    // skid fill and drain, in_valid ignored while full
    bus.out_ready = 1'b0;
    drive(1, 10, 1, 1, 1, 1, 1, 3, 5, 9);
    step();
    chk("t2_a_ready", bus.in_ready, 1);
    chk("t2_a_npc", bus.npcout, 10);
    drive(1, 5, 2, 2, 2, 2, 2, 2, 2, 4);
    step();
    chk("t2_b_ready", bus.in_ready, 0);
    chk("t2_b_npc", bus.npcout, 10);
    chk("t2_b_ex", bus.ex_ctlout, 9);
    drive(1, 7, 3, 3, 3, 3, 3, 1, 1, 1);
    step();
    chk("t2_c_ready", bus.in_ready, 0);
    chk("t2_c_npc", bus.npcout, 10);
    idle();
    bus.out_ready = 1'b1;
    step();
    chk("t2_d_valid", bus.out_valid, 1);
    chk("t2_d_npc", bus.npcout, 5);
    chk("t2_d_ex", bus.ex_ctlout, 4);
    chk("t2_d_ready", bus.in_ready, 1);
    step();
    chk("t2_e_valid", bus.out_valid, 0);

    // streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      drive(1, i, i, i, i, 5'(i), 5'(i), 1, 2, 3);
      step();
      chk("t3_npc", bus.npcout, 64'(i));
      chk("t3_valid", bus.out_valid, 1);
      chk("t3_ready", bus.in_ready, 1);
    end
    idle();
    step();
    chk("t3_end_valid", bus.out_valid, 0);

    // flush with both entries held
    bus.out_ready = 1'b0;
    drive(1, 20, 0, 0, 0, 0, 0, 1, 1, 1);
    step();
    drive(1, 21, 0, 0, 0, 0, 0, 2, 2, 2);
    step();
    chk("t4_full", bus.in_ready, 0);
    drive(1, 9, 0, 0, 0, 0, 0, 3, 3, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("t4_valid", bus.out_valid, 0);
    chk("t4_wb", bus.wb_ctlout, 0);
    chk("t4_m", bus.m_ctlout, 0);
    chk("t4_ex", bus.ex_ctlout, 0);
    chk("t4_ready", bus.in_ready, 1);
    chk("t4_npc", bus.npcout, 20);
    bus.out_ready = 1'b1;
    step();
    chk("t4_after_valid", bus.out_valid, 0);
    chk("t4_after_npc", bus.npcout, 20);
    drive(1, 9, 0, 0, 0, 0, 0, 3, 3, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("t4_empty_valid", bus.out_valid, 0);
    chk("t4_empty_npc", bus.npcout, 20);

    // asynchronous reset between edges
    bus.out_ready = 1'b0;
    drive(1, 33, 4, 4, 4, 4, 4, 3, 7, 15);
    step();
    idle();
    chk("t5_pre_valid", bus.out_valid, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("t5_valid", bus.out_valid, 0);
    chk("t5_npc", bus.npcout, 0);
    chk("t5_wb", bus.wb_ctlout, 0);
    chk("t5_ex", bus.ex_ctlout, 0);
    chk("t5_ready", bus.in_ready, 1);
    #2;
    rst = 1'b1;
    step();
    drive(1, 44, 0, 0, 0, 0, 0, 1, 0, 0);
    bus.out_ready = 1'b1;
    step();
    idle();
    chk("t5_re_valid", bus.out_valid, 1);
    chk("t5_re_npc", bus.npcout, 44);
    step();

`ifdef ID_EX_STALL_CNT_EN
    rst = 1'b0;
    #2;
    chk("t6_rst_cnt", stall_cnt, 0);
    rst = 1'b1;
    step();
    bus.out_ready = 1'b0;
    drive(1, 50, 0, 0, 0, 0, 0, 1, 1, 1);
    step();
    idle();
    repeat (7) step();
    chk("t6_cnt7", stall_cnt, 7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_flush_cnt", stall_cnt, 7);
    chk("t6_flush_valid", bus.out_valid, 0);
    step();
    chk("t6_hold_cnt", stall_cnt, 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_skid.md
ID_EX_SKID -- requirements
Module: id_ex_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of npc/readdat1/readdat2/signext_out paths.
REQ-002 Parameter REG_W, default 5, width of register-number fields.
REQ-003 Parameter WB_W, default 2, width of WB control field.
REQ-004 Parameter M_W, default 3, width of MEM control field.
REQ-005 Parameter EX_W, default 4, width of EX control field.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst  in  1  reset; asynchronous, active-low.
REQ-008 flush  in  1  discard all held and incoming entries this cycle.
REQ-009 in_valid  in  1  ID presents an entry.
REQ-010 in_ready  out  1  stage can accept an entry.
REQ-011 ctlwb_out / ctlm_out / ctlex_out  in  WB_W/M_W/EX_W  control fields from ID.
REQ-012 npc / readdat1 / readdat2 / signext_out  in  DATA_W each  ID data fields.
REQ-013 instr_2016 / instr_1511  in  REG_W each  rt / rd numbers.
REQ-014 out_valid  out  1  EX-side entry valid.
REQ-015 out_ready  in  1  EX accepts entry.
REQ-016 wb_ctlout / m_ctlout / ex_ctlout  out  WB_W/M_W/EX_W  registered control.
REQ-017 npcout / rdata1out / rdata2out / s_extendout  out  DATA_W each  registered data.
REQ-018 instrout_2016 / instrout_1511  out  REG_W each  registered rt / rd.
REQ-019 stall_cnt  out  16  stall-cycle count (present only with ID_EX_STALL_CNT_EN).

Function
REQ-020 Storage SHALL be two entries: main (drives outputs) and skid; order strictly FIFO.
REQ-021 Push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at the rising edge.
REQ-022 in_ready SHALL be a registered signal equal to "skid empty"; no combinational in->out ready path.
REQ-023 Latency: entry pushed into empty stage appears on outputs with out_valid=1 the next cycle.
REQ-024 Main empty, push: main loads input.
REQ-025 Main full, no pop, push: skid loads input; in_ready drops next cycle.
REQ-026 Main full, pop, skid full: main loads skid; skid loads input if pushed, else empties.
REQ-027 Main full, pop, skid empty, push: main loads input (full throughput, one entry/cycle).
REQ-028 Skid full: in_ready=0, in_valid ignored; no entry dropped or duplicated.
REQ-029 out_valid=0: wb_ctlout, m_ctlout, ex_ctlout SHALL read zero (bubble); data outputs hold last value.
REQ-030 flush=1: next cycle both entries invalid, control outputs zero, in_ready=1; same-cycle push discarded; flush overrides push and pop.
REQ-031 Outputs SHALL change only on clk edge or reset; all outputs registered.

Reset
REQ-032 rst low asynchronously clears both entries: out_valid=0, in_ready=1, all control and data outputs zero.
REQ-033 Reset mid-transfer SHALL lose held entries; first push after rst release behaves as REQ-024.

Configuration
REQ-034 Macro ID_EX_STALL_CNT_EN defined: stall_cnt port exists, increments each cycle with out_valid=1 & out_ready=0, saturates at 16'hFFFF, cleared by reset only (not flush).
REQ-035 Macro undefined: stall_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-036 Reset low then release; push npc=10, readdat1=15, readdat2=20, signext=20, rt=2, rd=2, ctlwb=1, ctlm=1, ctlex=2, out_ready=1 -> next cycle out_valid=1, all outputs match.
REQ-037 out_ready=0, push A(npc=10) then B(npc=5) -> in_ready=0 after B; release out_ready -> A then B on consecutive cycles, in_ready returns to 1.
REQ-038 Back-to-back pushes npc=1..8, out_ready=1 -> outputs npc=1..8 one per cycle, in_ready never 0.
REQ-039 Two entries held, flush=1 with in_valid=1 (npc=9) -> next cycle out_valid=0, control outputs 0, npc=9 never appears.
REQ-040 Assert rst low asynchronously between edges with main full -> outputs zero immediately, out_valid=0 without clock edge.
REQ-041 With ID_EX_STALL_CNT_EN: hold valid entry, out_ready=0 for 7 cycles -> stall_cnt=7; flush -> stall_cnt stays 7.
